// File: rtl/tof_frame_collector.sv
// Multi-sensor ToF frame collector: round-robin intake into a ping-pong frame memory,
// publishing each frame once every {sensor, zone} has been written at least once.
module tof_frame_collector #(
  parameter int NUM_SENSORS = 8,
  parameter int ZONES       = 64,
  parameter int DIST_W      = 16,
  parameter int OVERWRITE   = 0,
  localparam int SIDX_W     = $clog2(NUM_SENSORS),
  localparam int ZIDX_W     = $clog2(ZONES)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_SENSORS-1:0]                 tof_valid,
  input  logic [NUM_SENSORS*(ZIDX_W+DIST_W)-1:0] tof_data,
  output logic [NUM_SENSORS-1:0]                 tof_ready,
  output logic                                   frame_valid,
  input  logic                                   frame_ack,
  input  logic [SIDX_W+ZIDX_W-1:0]               rd_addr,
  output logic [DIST_W-1:0]                      rd_data,
  output logic [15:0]                            frame_count,
  output logic                                   overrun
);

  localparam int ENT_W  = ZIDX_W + DIST_W;
  localparam int ADDR_W = SIDX_W + ZIDX_W;
  localparam int TOTAL  = NUM_SENSORS * ZONES;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);
  localparam bit OVERWRITE_EN = (OVERWRITE != 0);

  typedef enum logic [0:0] {
    COLLECT   = 1'b0,
    WAIT_BANK = 1'b1
  } state_t;

  state_t                 state_r, state_nx_s;
  logic                   wr_bank_r;
  logic [(1<<ADDR_W)-1:0] sb_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [SIDX_W-1:0]      ptr_r;
  logic                   frame_valid_r;
  logic [15:0]            frame_count_r;
  logic                   overrun_r;
  logic [DIST_W-1:0]      rd_data_r;
  logic [DIST_W-1:0]      mem_r [0:(1<<(ADDR_W+1))-1];

  logic              gnt_found_s;
  logic [SIDX_W-1:0] gnt_idx_s;
  logic [SIDX_W-1:0] cand_s;
  logic              active_s;
  logic              xfer_s;
  logic [ENT_W-1:0]  ent_s;
  logic [ZIDX_W-1:0] zone_s;
  logic [DIST_W-1:0] dist_s;
  logic [ADDR_W-1:0] sb_idx_s;
  logic              new_s;
  logic              complete_s;
  logic              bank_free_s;
  logic              swap_s;
  logic              drop_s;

  // Round-robin search: first valid sensor upward (wrapping) from the one after the last grant
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int i = 1; i <= NUM_SENSORS; i++) begin
      cand_s = SIDX_W'((int'(ptr_r) + i) % NUM_SENSORS);
      if (!gnt_found_s && tof_valid[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign active_s    = (state_r == COLLECT) && !reset;
  assign xfer_s      = active_s && gnt_found_s;
  assign ent_s       = tof_data[int'(gnt_idx_s)*ENT_W +: ENT_W];
  assign zone_s      = ent_s[ENT_W-1 -: ZIDX_W];
  assign dist_s      = ent_s[DIST_W-1:0];
  assign sb_idx_s    = {gnt_idx_s, zone_s};
  assign new_s       = ~sb_r[sb_idx_s];
  assign complete_s  = xfer_s && new_s && (cnt_r == LAST_CNT);
  assign bank_free_s = !frame_valid_r || frame_ack;

  // One-hot grant, suppressed outside collection and while reset is held
  always_comb begin
    tof_ready = '0;
    if (xfer_s) begin
      tof_ready[gnt_idx_s] = 1'b1;
    end else begin
      tof_ready = '0;
    end
  end

  // Next state and frame-level swap/drop decisions
  always_comb begin
    state_nx_s = state_r;
    swap_s     = 1'b0;
    drop_s     = 1'b0;
    case (state_r)
      COLLECT: begin
        if (complete_s && bank_free_s) begin
          swap_s = 1'b1;
        end else if (complete_s && OVERWRITE_EN) begin
          drop_s = 1'b1;
        end else if (complete_s) begin
          state_nx_s = WAIT_BANK;
        end else begin
          state_nx_s = COLLECT;
        end
      end
      WAIT_BANK: begin
        if (frame_ack) begin
          swap_s     = 1'b1;
          state_nx_s = COLLECT;
        end else begin
          state_nx_s = WAIT_BANK;
        end
      end
      default: state_nx_s = COLLECT;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Scoreboard, bank select, publication bookkeeping and registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_r     <= 1'b0;
      sb_r          <= '0;
      cnt_r         <= '0;
      ptr_r         <= SIDX_W'(NUM_SENSORS - 1);
      frame_valid_r <= 1'b0;
      frame_count_r <= 16'd0;
      overrun_r     <= 1'b0;
      rd_data_r     <= '0;
    end else begin
      if (xfer_s) begin
        ptr_r <= gnt_idx_s;
      end
      // A completing transfer need not mark its bit: the whole scoreboard clears on that edge
      if (swap_s || drop_s) begin
        sb_r  <= '0;
        cnt_r <= '0;
      end else if (xfer_s) begin
        sb_r[sb_idx_s] <= 1'b1;
        if (new_s) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
      if (swap_s) begin
        wr_bank_r     <= ~wr_bank_r;
        frame_valid_r <= 1'b1;
        frame_count_r <= frame_count_r + 16'd1;
      end else if (frame_ack) begin
        frame_valid_r <= 1'b0;
      end
      overrun_r <= drop_s;
      rd_data_r <= mem_r[{~wr_bank_r, rd_addr}];
    end
  end

  // Frame memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_r[{wr_bank_r, sb_idx_s}] <= dist_s;
    end
  end

  assign frame_valid = frame_valid_r;
  assign frame_count = frame_count_r;
  assign overrun     = overrun_r;
  assign rd_data     = rd_data_r;

endmodule

// File: tb/tb_tof_frame_collector.sv
// Bench for tof_frame_collector: one hold instance and one overwrite instance share stimulus;
// each is checked every cycle against a set-based frame model, plus literal scenario checks.
module tb_tof_frame_collector;

  localparam int NS  = 2;
  localparam int NZ  = 4;
  localparam int DW  = 16;
  localparam int ZW  = 2;
  localparam int EW  = ZW + DW;
  localparam int TOT = NS * NZ;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   tof_valid;
  logic [NS*EW-1:0] tof_data;
  logic            frame_ack;
  logic [2:0]      rd_addr;

  logic [NS-1:0] rdy [2];
  logic          fv  [2];
  logic [DW-1:0] rdd [2];
  logic [15:0]   fc  [2];
  logic          ovr [2];

  always #5 clk = ~clk;

  tof_frame_collector #(.NUM_SENSORS(NS), .ZONES(NZ), .DIST_W(DW), .OVERWRITE(0)) dut_hold (
    .clk(clk), .reset(reset), .tof_valid(tof_valid), .tof_data(tof_data), .tof_ready(rdy[0]),
    .frame_valid(fv[0]), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rdd[0]),
    .frame_count(fc[0]), .overrun(ovr[0]));

  tof_frame_collector #(.NUM_SENSORS(NS), .ZONES(NZ), .DIST_W(DW), .OVERWRITE(1)) dut_drop (
    .clk(clk), .reset(reset), .tof_valid(tof_valid), .tof_data(tof_data), .tof_ready(rdy[1]),
    .frame_valid(fv[1]), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rdd[1]),
    .frame_count(fc[1]), .overrun(ovr[1]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Frame model: per instance, a set of written {sensor, zone} keys and two banks of values
  int mm_mem   [2][2][TOT];
  bit mm_known [2][2][TOT];
  bit mm_seen  [2][TOT];
  int mm_wb    [2];
  int mm_fc    [2];
  int mm_ptr   [2];
  int mm_rd    [2];
  bit mm_fv    [2];
  bit mm_wait  [2];
  bit mm_ovr   [2];
  bit mm_rdk   [2];

  task automatic model_reset(input int k);
    mm_wb[k]   = 0;
    mm_fc[k]   = 0;
    mm_ptr[k]  = NS - 1;
    mm_fv[k]   = 1'b0;
    mm_wait[k] = 1'b0;
    mm_ovr[k]  = 1'b0;
    mm_rd[k]   = 0;
    mm_rdk[k]  = 1'b1;
    for (int i = 0; i < TOT; i++) mm_seen[k][i] = 1'b0;
  endtask

  task automatic model_cycle(input int k);
    int g, s, z, d, a, cnt;
    logic [EW-1:0] ent;
    logic [NS-1:0] er;
    bit free, swap;
    if (reset) model_reset(k);
    g = -1;
    if (!reset && !mm_wait[k]) begin
      for (int i = 1; i <= NS; i++) begin
        s = (mm_ptr[k] + i) % NS;
        if (g < 0 && ((tof_valid >> s) & 2'b01) != 2'b00) g = s;
      end
    end
    er = (g >= 0) ? NS'(1 << g) : '0;
    chk($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(er));
    chk($sformatf("frame_valid[%0d]", k), 32'(fv[k]), 32'(mm_fv[k]));
    chk($sformatf("frame_count[%0d]", k), 32'(fc[k]), mm_fc[k]);
    chk($sformatf("overrun[%0d]", k), 32'(ovr[k]), 32'(mm_ovr[k]));
    if (mm_rdk[k]) chk($sformatf("rd_data[%0d]", k), 32'(rdd[k]), mm_rd[k]);
    if (reset) return;
    mm_rd[k]  = mm_mem[k][1 - mm_wb[k]][int'(rd_addr)];
    mm_rdk[k] = mm_known[k][1 - mm_wb[k]][int'(rd_addr)];
    mm_ovr[k] = 1'b0;
    free = !mm_fv[k] || frame_ack;
    swap = 1'b0;
    if (mm_wait[k]) begin
      if (frame_ack) swap = 1'b1;
    end else if (g >= 0) begin
      ent = EW'(tof_data >> (g * EW));
      z = int'(ent[EW-1 -: ZW]);
      d = int'(ent[DW-1:0]);
      a = g * NZ + z;
      mm_mem[k][mm_wb[k]][a]   = d;
      mm_known[k][mm_wb[k]][a] = 1'b1;
      mm_seen[k][a] = 1'b1;
      mm_ptr[k] = g;
      cnt = 0;
      for (int i = 0; i < TOT; i++) cnt += int'(mm_seen[k][i]);
      if (cnt == TOT) begin
        if (free) swap = 1'b1;
        else if (k == 1) begin
          for (int i = 0; i < TOT; i++) mm_seen[k][i] = 1'b0;
          mm_ovr[k] = 1'b1;
        end else mm_wait[k] = 1'b1;
      end
    end
    if (swap) begin
      mm_wb[k]   = 1 - mm_wb[k];
      mm_fv[k]   = 1'b1;
      mm_fc[k]   = (mm_fc[k] + 1) & 16'hFFFF;
      mm_wait[k] = 1'b0;
      for (int i = 0; i < TOT; i++) mm_seen[k][i] = 1'b0;
    end else if (frame_ack) begin
      mm_fv[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  task automatic set_ent(input int s, input int z, input int d);
    tof_data[s*EW +: EW] = {ZW'(z), DW'(d)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int s, input int z, input int d);
    tof_valid = NS'(1 << s);
    set_ent(s, z, d);
    tick();
  endtask

  // Both sensors present zone c/2 for two cycles; with all valids high grants alternate 0,1
  task automatic alt_frame(input int base, input bit ack_last, input string tag);
    for (int c = 0; c < 2 * NZ; c++) begin
      set_ent(0, c / 2, base + c / 2);
      set_ent(1, c / 2, base + 16 + c / 2);
      tof_valid = 2'b11;
      frame_ack = ack_last && (c == 2 * NZ - 1);
      #1;
      chk(tag, 32'(rdy[0]), (c % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    frame_ack = 1'b0;
    tof_valid = 2'b00;
  endtask

  initial begin
    reset     = 1'b1;
    tof_valid = '0;
    tof_data  = '0;
    frame_ack = 1'b0;
    rd_addr   = '0;
    repeat (2) @(posedge clk);
    #1;
    tof_valid = 2'b11;
    #1;
    chk("reset_ready", 32'(rdy[0]), 32'h0);
    chk("reset_frame_valid", 32'(fv[0]), 32'h0);
    chk("reset_count", 32'(fc[0]), 32'h0);
    chk("reset_rd_data", 32'(rdd[0]), 32'h0);
    reset = 1'b0;

    // First frame: alternating grants, publish after 8 transfers, read {1,2}
    alt_frame(1000, 1'b0, "alt_grant_f1");
    rd_addr = 3'b110;
    chk("f1_valid", 32'(fv[0]), 32'h1);
    chk("f1_count", 32'(fc[0]), 32'h1);
    tick();
    chk("f1_read_s1z2", 32'(rdd[0]), 32'd1018);
    chk("f1_read_s1z2_ow", 32'(rdd[1]), 32'd1018);

    // Second frame with a duplicate zone while the read bank is held
    put(0, 3, 100);
    put(0, 3, 200);
    for (int z = 0; z < 3; z++) put(0, z, 2000 + z);
    for (int z = 0; z < 3; z++) put(1, z, 2010 + z);
    chk("dup_not_counted", 32'(fc[0]), 32'h1);
    put(1, 3, 2013);
    chk("overrun_pulse", 32'(ovr[1]), 32'h1);
    chk("overrun_count_held", 32'(fc[1]), 32'h1);
    chk("hold_count", 32'(fc[0]), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tof_valid = 2'b01;
      set_ent(0, 0, 3333);
      #1;
      chk("wait_ready_low", 32'(rdy[0]), 32'h0);
      if (i == 1) chk("overrun_one_cycle", 32'(ovr[1]), 32'h0);
      tick();
    end
    tof_valid = 2'b00;
    frame_ack = 1'b1;
    rd_addr   = 3'b011;
    tick();
    frame_ack = 1'b0;
    chk("ack_swap_count", 32'(fc[0]), 32'h2);
    chk("ack_swap_valid", 32'(fv[0]), 32'h1);
    chk("ack_release_ow", 32'(fv[1]), 32'h0);
    tick();
    chk("dup_read_200", 32'(rdd[0]), 32'd200);
    chk("ow_bank_kept", 32'(rdd[1]), 32'd1003);

    // Third frame: acknowledge on the very completion edge
    alt_frame(3000, 1'b1, "alt_grant_f3");
    chk("ack_on_complete_count", 32'(fc[0]), 32'h3);
    chk("ack_on_complete_valid", 32'(fv[0]), 32'h1);
    tof_valid = 2'b11;
    #1;
    chk("no_wait_after_ack", 32'(rdy[0]), 32'h1);
    tof_valid = 2'b00;
    tick();

    // Reset after 5 of 8 transfers, then a full fresh frame is required
    for (int c = 0; c < 5; c++) begin
      set_ent(0, c / 2, 4000 + c / 2);
      set_ent(1, c / 2, 4016 + c / 2);
      tof_valid = 2'b11;
      tick();
    end
    reset = 1'b1;
    #1;
    chk("midreset_ready", 32'(rdy[0]), 32'h0);
    chk("midreset_valid", 32'(fv[0]), 32'h0);
    chk("midreset_count", 32'(fc[0]), 32'h0);
    chk("midreset_rd_data", 32'(rdd[0]), 32'h0);
    chk("midreset_overrun", 32'(ovr[1]), 32'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2 * NZ; c++) begin
      set_ent(0, c / 2, 5000 + c / 2);
      set_ent(1, c / 2, 5016 + c / 2);
      tof_valid = 2'b11;
      tick();
      if (c == 2 * NZ - 2) chk("no_early_complete", 32'(fv[0]), 32'h0);
    end
    chk("post_reset_frame", 32'(fv[0]), 32'h1);
    chk("post_reset_count", 32'(fc[0]), 32'h1);
    tof_valid = 2'b00;

    // Randomised traffic, acks, reads and occasional resets against the model
    for (int c = 0; c < 3000; c++) begin
      tof_valid = NS'($urandom_range(0, 3));
      for (int s = 0; s < NS; s++) set_ent(s, $urandom_range(0, NZ - 1), $urandom_range(0, 65535));
      frame_ack = ($urandom_range(0, 7) == 0);
      rd_addr   = 3'($urandom_range(0, 7));
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset     = 1'b0;
    tof_valid = '0;
    frame_ack = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tof_frame_collector.md
# tof_frame_collector

Parametrised multi-sensor ToF frame collector; successor to the fixed 8-sensor, 64-zone BRAM write path. Accepts distance samples from NUM_SENSORS sensor channels over a per-channel valid/ready handshake, arbitrates round-robin, and stores them in a double-buffered (ping-pong) frame memory. A frame is complete when every zone of every sensor has been written at least once; a bank swap then publishes it to the downstream surface/plane calculators through a frame_valid/frame_ack handshake and a registered read port.

## Interface
- NUM_SENSORS, 8, sensor channel count (≥2); SIDX_W = clog2(NUM_SENSORS)
- ZONES, 64, zones per sensor, power of two; ZIDX_W = clog2(ZONES)
- DIST_W, 16, distance word width (mm)
- OVERWRITE, 0, 0 = stall inputs while the read bank is held; 1 = drop the completed frame and restart collection
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- tof_valid  in  NUM_SENSORS  per-sensor sample valid
- tof_data  in  NUM_SENSORS*(ZIDX_W+DIST_W)  sensor s at [s*(ZIDX_W+DIST_W) +: ZIDX_W+DIST_W], packed {zone, distance}
- tof_ready  out  NUM_SENSORS  one-hot-or-zero grant; a transfer occurs when tof_valid[s] && tof_ready[s]
- frame_valid  out  1  complete frame held in read bank
- frame_ack  in  1  reader releases read bank
- rd_addr  in  SIDX_W+ZIDX_W  {sensor, zone} of read bank
- rd_data  out  DIST_W  registered read data
- frame_count  out  16  published frames, wraps 0xFFFF→0
- overrun  out  1  one-cycle pulse when a completed frame is dropped (OVERWRITE=1 only)

## Operation
- States: COLLECT, WAIT_BANK. Reset → COLLECT, wr_bank=0, scoreboard all 0, zone counter 0, RR pointer at sensor NUM_SENSORS-1, frame_valid=0, frame_count=0, overrun=0, rd_data=0, tof_ready=0.
- Arbitration (COLLECT only): tof_ready combinational; grants the first asserted tof_valid searching upward (wrapping) from pointer+1. Pointer updates to granted sensor on transfer. WAIT_BANK or reset: tof_ready=0.
- Write: mem[{wr_bank, s, zone}] <= distance. Scoreboard bit {s,zone} set; zone counter increments only if the bit was previously clear (duplicates overwrite data, never double-count).
- Completion: transfer that brings counter to NUM_SENSORS*ZONES.
  - Read bank free (frame_valid=0, or frame_ack asserted same cycle): at that edge wr_bank toggles, scoreboard and counter clear, frame_valid=1, frame_count+1; stay COLLECT.
  - Read bank held, OVERWRITE=0: → WAIT_BANK, wr_bank/scoreboard unchanged. On frame_ack: perform swap as above, → COLLECT.
  - Read bank held, OVERWRITE=1: scoreboard and counter clear, wr_bank unchanged, overrun=1 for one cycle, frame_count unchanged; stay COLLECT.
- frame_ack with frame_valid=1 and no simultaneous swap: frame_valid→0 next edge. frame_ack with frame_valid=0: ignored.
- Read: rd_data <= mem[{~wr_bank, rd_addr}] every cycle; contents undefined before the first frame_valid.
- Reset mid-frame: partial frame discarded (scoreboard cleared); memory contents are not cleared.

## Timing
- Handshake: zero-latency grant; one sample per cycle maximum throughput.
- Completion edge to frame_valid high: same edge (visible next cycle); first new-frame transfer possible the following cycle (no dead cycle).
- WAIT_BANK exit: swap on the frame_ack edge; tof_ready may assert the next cycle.
- rd_data: 1-cycle latency from rd_addr; changes bank on the cycle after a swap.
- overrun: high exactly one cycle after the dropping edge.

## Test plan
- NUM_SENSORS=2, ZONES=4: all valids high, sequential zones → grants alternate 0,1,0,1…; after 8 transfers frame_valid=1, frame_count=1; rd_addr={1,2} returns sensor 1 zone 2 distance one cycle later.
- Send zone 3 of sensor 0 twice (values 100 then 200) within a frame → completion still after 8 distinct zones; read returns 200.
- OVERWRITE=0, frame_valid held, second frame completes → state WAIT_BANK, tof_ready=0 for 20 cycles; frame_ack → frame_count=2, frame_valid stays 1, ready resumes next cycle.
- OVERWRITE=1, same stimulus → one-cycle overrun pulse, frame_count stays 1, collection restarts, read bank data unchanged.
- frame_ack asserted on the exact completion edge → swap happens, frame_valid remains 1, frame_count increments, no WAIT_BANK entry.
- Assert reset after 5 of 8 transfers → outputs return to reset values immediately; frame completes only after 8 further distinct zones.
